fwd_ctrl: RTL and testbench



---
 rtl/fwd_pkg.sv | 22 ++
 rtl/fwd_decode.sv | 41 ++++
 rtl/fwd_ctrl.sv | 99 +++++++++
 tb/tb_fwd_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared opcode constants and scoreboard entry type
// for the forwarding / hazard controller.
package fwd_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_decode.sv
// Register-usage decode of the instruction sitting in decode:
// which of rd/rs1/rs2 are real and whether it is a load.
module fwd_decode
  import fwd_pkg::*;
(
  input  logic [31:0] inst,
  output logic        has_rd,
  output logic        has_rs1,
  output logic        has_rs2,
  output logic        is_load,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] opc;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opc    = inst[6:0];
  assign funct3 = inst[14:12];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign unused_bits = ^{inst[31:25], funct3[1:0]};

  assign has_rd = (opc != OPC_BRANCH) && (opc != OPC_STORE)
                && (rd != 5'd0);

  // CSR immediate forms reuse the rs1 field as a zimm
  assign has_rs1 = (opc != OPC_LUI) && (opc != OPC_AUIPC)
                 && (opc != OPC_JAL)
                 && !((opc == OPC_CSR) && funct3[2]);

  assign has_rs2 = (opc == OPC_ARI_RTYPE) || (opc == OPC_STORE)
                 || (opc == OPC_BRANCH);

  assign is_load = (opc == OPC_LOAD);

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding select and load-use stall generation from a
// shift-register scoreboard of in-flight destinations.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int LOAD_BUBBLES = 1,
  parameter int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dec_inst,
  input  logic             dec_valid,
  input  logic             flush,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             stall,
  output logic [31:0]      stall_count
);

  logic       has_rd;
  logic       has_rs1;
  logic       has_rs2;
  logic       is_load;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  fwd_decode u_dec (
    .inst    (dec_inst),
    .has_rd  (has_rd),
    .has_rs1 (has_rs1),
    .has_rs2 (has_rs2),
    .is_load (is_load),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2)
  );

  sb_entry_t sb [1:DEPTH];

  logic [SEL_W-1:0] sel1;
  logic [SEL_W-1:0] sel2;
  logic             ld1;
  logic             ld2;
  logic             use1;
  logic             use2;

  assign use1 = dec_valid && has_rs1 && (rs1 != 5'd0);
  assign use2 = dec_valid && has_rs2 && (rs2 != 5'd0);

  // Walk oldest to youngest so the youngest writer wins
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    ld1  = 1'b0;
    ld2  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use1 && sb[k].valid && (sb[k].rd == rs1)) begin
        sel1 = SEL_W'(k);
        ld1  = sb[k].is_load && (k <= LOAD_BUBBLES);
      end
      if (use2 && sb[k].valid && (sb[k].rd == rs2)) begin
        sel2 = SEL_W'(k);
        ld2  = sb[k].is_load && (k <= LOAD_BUBBLES);
      end
    end
  end

  assign stall    = !flush && (ld1 || ld2);
  assign fwd_sel1 = flush ? '0 : sel1;
  assign fwd_sel2 = flush ? '0 : sel2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
    end else if (flush) begin
      for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) sb[k] <= sb[k-1];
      if (stall) begin
        sb[1] <= '0;
      end else begin
        sb[1] <= '{valid:   has_rd & dec_valid,
                   rd:      rd,
                   is_load: is_load};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed hazard sequences
// plus random traffic checked against a history-list model.
module tb_fwd_ctrl;

  localparam int DEPTH = 2;
  localparam int LB    = 1;
  localparam int SW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   dec_inst = 32'h0;
  logic          dec_valid = 1'b0;
  logic          flush = 1'b0;
  logic [SW-1:0] fwd_sel1;
  logic [SW-1:0] fwd_sel2;
  logic          stall;
  logic [31:0]   stall_count;

  fwd_ctrl #(.DEPTH(DEPTH), .LOAD_BUBBLES(LB)) dut (
    .clk         (clk),
    .rst         (rst),
    .dec_inst    (dec_inst),
    .dec_valid   (dec_valid),
    .flush       (flush),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s1;
    int          s2;
    bit          st;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    bit       w;
    bit [4:0] rd;
    bit       ld;
  } rec_t;

  exp_t exp_q[$];
  rec_t hist[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", {31'd0, stall}, {31'd0, e.st});
      chk("stall_count", stall_count, e.cnt);
      if (!e.st) begin
        chk("fwd_sel1", 32'(fwd_sel1), 32'(e.s1));
        chk("fwd_sel2", 32'(fwd_sel2), 32'(e.s2));
      end
    end
  end

  // Reference: register usage straight from the ISA opcode map
  function automatic void usage(input logic [31:0] i,
      output bit wr, output bit u1, output bit u2, output bit ld);
    logic [6:0] op;
    op = i[6:0];
    wr = 1; u1 = 1; u2 = 0; ld = 0;
    case (op)
      7'b1100011: begin wr = 0; u2 = 1; end
      7'b0100011: begin wr = 0; u2 = 1; end
      7'b0110011: u2 = 1;
      7'b0110111, 7'b0010111, 7'b1101111: u1 = 0;
      7'b1110011: u1 = !i[14];
      7'b0000011: ld = 1;
      default: ;
    endcase
    if (i[11:7] == 0) wr = 0;
  endfunction

  function automatic int find(input bit [4:0] r);
    for (int j = 0; j < hist.size() && j < DEPTH; j++)
      if (hist[j].w && hist[j].rd == r) return j + 1;
    return 0;
  endfunction

  task automatic step(input logic [31:0] i, input logic v,
                      input logic f);
    exp_t e;
    rec_t r;
    bit wr, u1, u2, ld;
    int a1, a2;
    @(posedge clk);
    #1;
    dec_inst = i; dec_valid = v; flush = f;
    usage(i, wr, u1, u2, ld);
    a1 = (v && u1 && i[19:15] != 0) ? find(i[19:15]) : 0;
    a2 = (v && u2 && i[24:20] != 0) ? find(i[24:20]) : 0;
    e.st = !f && ((a1 != 0 && hist[a1-1].ld && a1 <= LB)
               || (a2 != 0 && hist[a2-1].ld && a2 <= LB));
    e.s1 = f ? 0 : a1;
    e.s2 = f ? 0 : a2;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (e.st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (f) begin
      hist.delete();
    end else begin
      r.w = v && wr && !e.st; r.rd = i[11:7]; r.ld = ld;
      hist.push_front(r);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  endtask

  function automatic logic [31:0] r_op(input int rd, input int a,
                                       input int b);
    return {7'd0, 5'(b), 5'(a), 3'd0, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_op(input logic [6:0] op,
      input int rd, input int a);
    return {12'd4, 5'(a), 3'b010, 5'(rd), op};
  endfunction
  function automatic logic [31:0] s_op(input int b, input int a);
    return {7'd0, 5'(b), 5'(a), 3'b010, 5'd0, 7'b0100011};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    logic [6:0] ops [10];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0100011, 7'b0000011, 7'b0010011,
            7'b0110011, 7'b1110011};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_sel1", 32'(fwd_sel1), 32'd0);
    chk("rst_sel2", 32'(fwd_sel2), 32'd0);
    chk("rst_count", stall_count, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // back-to-back ALU dependence
    step(r_op(5, 1, 2), 1, 0);
    step(r_op(6, 5, 5) | 32'h4000_0000, 1, 0);
    // youngest wins and distance two
    step(r_op(7, 1, 2), 1, 0);
    step(r_op(7, 3, 4) | 32'h0000_6000, 1, 0);
    step(r_op(8, 7, 0), 1, 0);
    step(r_op(7, 1, 2), 1, 0);
    step(NOP, 1, 0);
    step(r_op(9, 7, 1), 1, 0);
    // load-use stall then forward from stage 2
    step(i_op(7'b0000011, 3, 4), 1, 0);
    step(r_op(9, 3, 1), 1, 0);
    step(r_op(9, 3, 1), 1, 0);
    // x0 destination and non-source cases
    step(i_op(7'b0000011, 0, 1), 1, 0);
    step(r_op(2, 0, 0), 1, 0);
    step(r_op(5, 1, 2), 1, 0);
    step({20'h12345, 5'd5, 7'b0110111}, 1, 0);
    step(r_op(5, 1, 2), 1, 0);
    step(s_op(5, 6), 1, 0);
    // flush over a pending load-use stall
    step(i_op(7'b0000011, 3, 4), 1, 0);
    step(r_op(9, 3, 1), 1, 1);
    step(r_op(10, 3, 3), 1, 0);
    // async reset in the middle of a stall
    step(i_op(7'b0000011, 3, 4), 1, 0);
    step(r_op(9, 3, 1), 1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    dec_valid = 1'b0;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_count", stall_count, 32'd0);
    dec_valid = 1'b1;
    #1;
    chk("arst_sel1", 32'(fwd_sel1), 32'd0);
    dec_valid = 1'b0;
    hist.delete();
    m_cnt = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    step(r_op(9, 3, 3), 1, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = {7'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 3'($urandom),
             5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
      step(ins, ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
